// File: rtl/multicycle_sequencer.sv
// Multicycle instruction sequencer: FETCH -> DECODE -> (MEM) -> WB with req/ack
// memory handshakes, ebreak halt, bus-timeout fault and cycle/retire counters.
module multicycle_sequencer #(
    parameter int CNT_W   = 32,
    parameter int TO_W    = 8,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             if_ack_i,
    input  logic             is_load_i,
    input  logic             is_store_i,
    input  logic             is_ebreak_i,
    input  logic             wb_en_i,
    input  logic             mem_ack_i,
    output logic             if_req_o,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic             pc_wen_o,
    output logic             rf_wen_o,
    output logic             halt_o,
    output logic             fault_o,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] inst_cnt_o,
    output logic [2:0]       state_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_FAULT  = 3'd6
    } state_t;

    // Last wait count before a still-unacknowledged request becomes a fault.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t            state_q, state_d;
    logic              st_q, st_d;
    logic              wb_q, wb_d;
    logic [TO_W-1:0]   wait_q, wait_d;
    logic [CNT_W-1:0]  cycle_q, cycle_d;
    logic [CNT_W-1:0]  inst_q, inst_d;
    logic              timeout_hit;
    logic              active;

    assign timeout_hit = (TIMEOUT != 0) && (wait_q == TO_LAST);
    assign active = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                    (state_q == S_MEM)   || (state_q == S_WB);

    always_comb begin
        state_d = state_q;
        st_d    = st_q;
        wb_d    = wb_q;
        wait_d  = wait_q;
        inst_d  = inst_q;
        cycle_d = active ? cycle_q + CNT_W'(1) : cycle_q;
        case (state_q)
            S_IDLE: begin
                if (en_i) begin
                    state_d = S_FETCH;
                    wait_d  = '0;
                end
            end
            S_FETCH: begin
                if (if_ack_i) begin
                    state_d = S_DECODE;
                end else if (timeout_hit) begin
                    state_d = S_FAULT;
                end else begin
                    wait_d = wait_q + TO_W'(1);
                end
            end
            S_DECODE: begin
                st_d = is_store_i;
                wb_d = wb_en_i;
                if (is_load_i && is_store_i) begin
                    state_d = S_FAULT;
                end else if (is_ebreak_i) begin
                    state_d = S_HALT;
                    inst_d  = inst_q + CNT_W'(1);
                end else if (is_load_i || is_store_i) begin
                    state_d = S_MEM;
                    wait_d  = '0;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (mem_ack_i) begin
                    state_d = S_WB;
                end else if (timeout_hit) begin
                    state_d = S_FAULT;
                end else begin
                    wait_d = wait_q + TO_W'(1);
                end
            end
            S_WB: begin
                state_d = S_FETCH;
                wait_d  = '0;
                inst_d  = inst_q + CNT_W'(1);
            end
            default: begin
                // HALT and FAULT are absorbing; only reset leaves them.
                state_d = state_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            st_q    <= 1'b0;
            wb_q    <= 1'b0;
            wait_q  <= '0;
            cycle_q <= '0;
            inst_q  <= '0;
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            wb_q    <= wb_d;
            wait_q  <= wait_d;
            cycle_q <= cycle_d;
            inst_q  <= inst_d;
        end
    end

    assign if_req_o    = (state_q == S_FETCH);
    assign mem_req_o   = (state_q == S_MEM);
    assign mem_we_o    = (state_q == S_MEM) && st_q;
    assign pc_wen_o    = (state_q == S_WB);
    assign rf_wen_o    = (state_q == S_WB) && wb_q;
    assign halt_o      = (state_q == S_HALT);
    assign fault_o     = (state_q == S_FAULT);
    assign cycle_cnt_o = cycle_q;
    assign inst_cnt_o  = inst_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: vector table, randomized instruction stream
// against a per-instruction latency/count model, and hand-written corner cases.
module tb_multicycle_sequencer;

    localparam int CW   = 4;
    localparam int TO   = 4;
    localparam int MASK = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0, if_ack = 1'b0, is_load = 1'b0, is_store = 1'b0;
    logic          is_ebreak = 1'b0, wb_en = 1'b0, mem_ack = 1'b0;
    logic          if_req_o, mem_req_o, mem_we_o, pc_wen_o, rf_wen_o, halt_o, fault_o;
    logic [CW-1:0] cycle_cnt_o, inst_cnt_o;
    logic [2:0]    state_o;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc_m = 0;
    int inst_m = 0;

    multicycle_sequencer #(.CNT_W(CW), .TO_W(8), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en_i        (en),
        .if_ack_i    (if_ack),
        .is_load_i   (is_load),
        .is_store_i  (is_store),
        .is_ebreak_i (is_ebreak),
        .wb_en_i     (wb_en),
        .mem_ack_i   (mem_ack),
        .if_req_o    (if_req_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .pc_wen_o    (pc_wen_o),
        .rf_wen_o    (rf_wen_o),
        .halt_o      (halt_o),
        .fault_o     (fault_o),
        .cycle_cnt_o (cycle_cnt_o),
        .inst_cnt_o  (inst_cnt_o),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: actual=still running required=finished");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        int   fd;
        int   md;
        logic ld;
        logic st;
        logic wb;
        int   exp_cyc;
        int   exp_if;
        int   exp_mem;
        int   exp_we;
        int   exp_rf;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        en = 1'b0; if_ack = 1'b0; mem_ack = 1'b0;
        is_load = 1'b0; is_store = 1'b0; is_ebreak = 1'b0; wb_en = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) tick();
        rst_n = 1'b1;
        cyc_m = 0;
        inst_m = 0;
    endtask

    // From IDLE, raise en and advance into the first FETCH cycle.
    task automatic start_run();
        en = 1'b1;
        tick();
    endtask

    // Drives one instruction starting in FETCH, acting as instruction and data
    // memory with the requested ack delays; stray acks are randomized.
    task automatic run_instr(input int fd, input int md, input logic ld, input logic st,
                             input logic wb, output int cyc, output int ifc, output int memc,
                             output int wec, output int pcc, output int rfc, output logic ok);
        int   nif;
        int   nmem;
        logic done;
        nif = 0; nmem = 0; done = 1'b0; ok = 1'b1;
        cyc = 0; ifc = 0; memc = 0; wec = 0; pcc = 0; rfc = 0;
        for (int g = 0; g < 40 && !done; g++) begin
            if_ack = 1'($urandom); mem_ack = 1'($urandom);
            is_load = 1'($urandom); is_store = 1'($urandom);
            is_ebreak = 1'($urandom); wb_en = 1'($urandom);
            ifc += int'(if_req_o); memc += int'(mem_req_o); wec += int'(mem_we_o);
            pcc += int'(pc_wen_o); rfc += int'(rf_wen_o);
            case (state_o)
                3'd1: begin if_ack = (nif == fd); nif++; end
                3'd2: begin is_load = ld; is_store = st; is_ebreak = 1'b0; wb_en = wb; end
                3'd3: begin mem_ack = (nmem == md); nmem++; end
                3'd4: done = 1'b1;
                default: begin ok = 1'b0; done = 1'b1; end
            endcase
            if (ok) cyc++;
            tick();
        end
        if (!done) ok = 1'b0;
        if_ack = 1'b0; mem_ack = 1'b0;
    endtask

    task automatic apply(input string tag, input vec_t v);
        int cyc, ifc, memc, wec, pcc, rfc;
        logic ok;
        run_instr(v.fd, v.md, v.ld, v.st, v.wb, cyc, ifc, memc, wec, pcc, rfc, ok);
        cyc_m  += v.exp_cyc;
        inst_m += 1;
        chk({tag, " completed"}, 32'(ok), 1);
        chk({tag, " latency"}, cyc, v.exp_cyc);
        chk({tag, " if_req cycles"}, ifc, v.exp_if);
        chk({tag, " mem_req cycles"}, memc, v.exp_mem);
        chk({tag, " mem_we cycles"}, wec, v.exp_we);
        chk({tag, " pc_wen pulses"}, pcc, 1);
        chk({tag, " rf_wen pulses"}, rfc, v.exp_rf);
        chk({tag, " back to FETCH"}, 32'(state_o), 1);
        chk({tag, " inst_cnt"}, 32'(inst_cnt_o), inst_m & MASK);
        chk({tag, " cycle_cnt"}, 32'(cycle_cnt_o), cyc_m & MASK);
        $display("%s fd=%0d md=%0d ld=%0b st=%0b wb=%0b cycles=%0d inst_cnt=%0d cycle_cnt=%0d",
                 tag, v.fd, v.md, v.ld, v.st, v.wb, cyc, inst_cnt_o, cycle_cnt_o);
    endtask

    vec_t tbl[6];

    initial begin
        int cnt;
        int c0;
        vec_t r;

        tbl[0] = '{fd:2, md:3, ld:1, st:0, wb:1, exp_cyc:9, exp_if:3, exp_mem:4, exp_we:0, exp_rf:1};
        tbl[1] = '{fd:2, md:3, ld:0, st:1, wb:0, exp_cyc:9, exp_if:3, exp_mem:4, exp_we:4, exp_rf:0};
        tbl[2] = '{fd:0, md:0, ld:0, st:0, wb:0, exp_cyc:3, exp_if:1, exp_mem:0, exp_we:0, exp_rf:0};
        tbl[3] = '{fd:3, md:0, ld:0, st:0, wb:1, exp_cyc:6, exp_if:4, exp_mem:0, exp_we:0, exp_rf:1};
        tbl[4] = '{fd:0, md:0, ld:1, st:0, wb:1, exp_cyc:4, exp_if:1, exp_mem:1, exp_we:0, exp_rf:1};
        tbl[5] = '{fd:1, md:3, ld:0, st:1, wb:1, exp_cyc:8, exp_if:2, exp_mem:4, exp_we:4, exp_rf:1};

        // Reset state
        #2;
        chk("reset state", 32'(state_o), 0);
        chk("reset if_req", 32'(if_req_o), 0);
        chk("reset pc_wen", 32'(pc_wen_o), 0);
        chk("reset halt|fault", 32'(halt_o | fault_o), 0);
        chk("reset cycle_cnt", 32'(cycle_cnt_o), 0);
        chk("reset inst_cnt", 32'(inst_cnt_o), 0);
        $display("reset: state=%0d cycle_cnt=%0d inst_cnt=%0d", state_o, cycle_cnt_o, inst_cnt_o);
        do_reset();
        if_ack = 1'b1; mem_ack = 1'b1;
        repeat (3) tick();
        chk("idle without en", 32'(state_o), 0);
        chk("idle cycle_cnt frozen", 32'(cycle_cnt_o), 0);
        if_ack = 1'b0; mem_ack = 1'b0;

        // First instruction: ALU op, 1-cycle fetch, states 0,1,2,4,1
        start_run();
        chk("alu0 FETCH", 32'(state_o), 1);
        chk("alu0 if_req", 32'(if_req_o), 1);
        if_ack = 1'b1;
        tick();
        if_ack = 1'b0; wb_en = 1'b1;
        chk("alu0 DECODE", 32'(state_o), 2);
        chk("alu0 pc_wen in DECODE", 32'(pc_wen_o), 0);
        tick();
        wb_en = 1'b0;
        chk("alu0 WB", 32'(state_o), 4);
        chk("alu0 pc_wen", 32'(pc_wen_o), 1);
        chk("alu0 rf_wen", 32'(rf_wen_o), 1);
        tick();
        chk("alu0 FETCH again", 32'(state_o), 1);
        chk("alu0 pc_wen after WB", 32'(pc_wen_o), 0);
        chk("alu0 inst_cnt", 32'(inst_cnt_o), 1);
        chk("alu0 cycle_cnt", 32'(cycle_cnt_o), 3);
        $display("alu0: inst_cnt=%0d cycle_cnt=%0d", inst_cnt_o, cycle_cnt_o);
        cyc_m = 3; inst_m = 1;

        foreach (tbl[i]) apply($sformatf("vec%0d", i), tbl[i]);

        // Randomized instruction stream against the latency/count model
        for (int k = 0; k < 30; k++) begin
            int kind;
            kind = int'($urandom_range(0, 2));
            r.fd = int'($urandom_range(0, TO - 1));
            r.md = int'($urandom_range(0, TO - 1));
            r.ld = (kind == 1);
            r.st = (kind == 2);
            r.wb = 1'($urandom);
            r.exp_if  = r.fd + 1;
            r.exp_mem = (kind != 0) ? r.md + 1 : 0;
            r.exp_we  = r.st ? r.exp_mem : 0;
            r.exp_rf  = int'(r.wb);
            r.exp_cyc = r.exp_if + 1 + r.exp_mem + 1;
            apply($sformatf("rnd%0d", k), r);
        end

        // Fetch timeout: exactly TO unacked request cycles, then sticky fault
        do_reset();
        start_run();
        cnt = 0;
        for (int g = 0; g < 10 && state_o == 3'd1; g++) begin
            cnt++;
            tick();
        end
        chk("timeout if_req cycles", cnt, TO);
        chk("timeout state", 32'(state_o), 6);
        chk("timeout fault", 32'(fault_o), 1);
        c0 = int'(cycle_cnt_o);
        chk("timeout cycle_cnt", c0, TO);
        for (int g = 0; g < 5; g++) begin
            if_ack = 1'($urandom); mem_ack = 1'($urandom); is_store = 1'($urandom);
            tick();
        end
        chk("fault sticky", 32'(fault_o), 1);
        chk("fault no if_req", 32'(if_req_o | mem_req_o), 0);
        chk("fault cycle_cnt frozen", 32'(cycle_cnt_o), c0);
        $display("timeout: if_req_cycles=%0d state=%0d fault=%0b", cnt, state_o, fault_o);

        // ebreak -> HALT, retires one, counters frozen afterwards
        do_reset();
        start_run();
        if_ack = 1'b1;
        tick();
        if_ack = 1'b0; is_ebreak = 1'b1;
        tick();
        is_ebreak = 1'b0;
        chk("ebreak state", 32'(state_o), 5);
        chk("ebreak halt", 32'(halt_o), 1);
        chk("ebreak inst_cnt", 32'(inst_cnt_o), 1);
        chk("ebreak cycle_cnt", 32'(cycle_cnt_o), 2);
        for (int g = 0; g < 10; g++) begin
            if_ack = 1'($urandom); mem_ack = 1'($urandom); en = 1'($urandom);
            tick();
            chk($sformatf("halt hold %0d state", g), 32'(state_o), 5);
            chk($sformatf("halt hold %0d cycle_cnt", g), 32'(cycle_cnt_o), 2);
        end
        chk("halt inst_cnt frozen", 32'(inst_cnt_o), 1);
        chk("halt no requests", 32'(if_req_o | mem_req_o | pc_wen_o), 0);
        $display("ebreak: state=%0d halt=%0b inst_cnt=%0d cycle_cnt=%0d", state_o, halt_o,
                 inst_cnt_o, cycle_cnt_o);

        // Illegal decode: load and store together
        do_reset();
        start_run();
        if_ack = 1'b1;
        tick();
        if_ack = 1'b0; is_load = 1'b1; is_store = 1'b1; wb_en = 1'b1;
        tick();
        is_load = 1'b0; is_store = 1'b0; wb_en = 1'b0;
        chk("illegal state", 32'(state_o), 6);
        chk("illegal fault", 32'(fault_o), 1);
        chk("illegal mem_req", 32'(mem_req_o), 0);
        chk("illegal inst_cnt", 32'(inst_cnt_o), 0);
        $display("illegal: state=%0d fault=%0b mem_req=%0b", state_o, fault_o, mem_req_o);

        // Asynchronous reset in the middle of a legal load's MEM phase
        do_reset();
        start_run();
        if_ack = 1'b1;
        tick();
        if_ack = 1'b0; is_load = 1'b1; wb_en = 1'b1;
        tick();
        is_load = 1'b0; wb_en = 1'b0; mem_ack = 1'b1;
        chk("mid-MEM state", 32'(state_o), 3);
        chk("mid-MEM mem_req", 32'(mem_req_o), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst state", 32'(state_o), 0);
        chk("async rst outputs", 32'({if_req_o, mem_req_o, mem_we_o, pc_wen_o, rf_wen_o,
                                      halt_o, fault_o}), 0);
        chk("async rst counters", 32'({cycle_cnt_o, inst_cnt_o}), 0);
        $display("async reset: state=%0d outputs cleared", state_o);
        tick();
        chk("held rst no pc_wen", 32'(pc_wen_o | rf_wen_o), 0);
        mem_ack = 1'b0;

        // Counter wrap: 16 non-memory 1-cycle-fetch instructions
        do_reset();
        start_run();
        for (int k = 0; k < 16; k++) begin
            r = '{fd:0, md:0, ld:0, st:0, wb:1, exp_cyc:3, exp_if:1, exp_mem:0, exp_we:0, exp_rf:1};
            apply($sformatf("wrap%0d", k), r);
        end
        chk("wrap inst_cnt zero", 32'(inst_cnt_o), 0);
        chk("wrap cycle_cnt zero", 32'(cycle_cnt_o), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
